// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS IF stage with PC, IF/ID register, stall, redirect and flush.
// Priority of the next-PC source: branch, then jump, then stall, then sequential fetch.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] instruction_i,
  output logic [31:0] instr_address_o,
  output logic [31:0] ifid_instruction_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_count_o
);
  logic [31:0] pc_q, pc_d, ins_q, ins_d, pc4_q, pc4_d, cnt_q, cnt_d;
  logic        v_q, v_d;
  logic        redirect;
  logic [31:0] target, pc_plus4;
  always_comb begin
    redirect = branch_taken_i | jump_i;
    target   = branch_taken_i ? branch_target_i : jump_target_i;
    pc_plus4 = pc_q + 32'd4;
    // a redirect discards the younger slot even when the hazard unit stalls it
    pc_d  = redirect ? {target[31:2], 2'b00} : stall_i ? pc_q : pc_plus4;
    ins_d = redirect ? 32'h0 : stall_i ? ins_q : instruction_i;
    pc4_d = redirect ? 32'h0 : stall_i ? pc4_q : pc_plus4;
    v_d   = redirect ? 1'b0 : stall_i ? v_q : 1'b1;
    cnt_d = (redirect | stall_i) ? cnt_q : cnt_q + 32'd1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= {RESET_PC[31:2], 2'b00};
      ins_q <= 32'h0;
      pc4_q <= 32'h0;
      v_q   <= 1'b0;
      cnt_q <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      ins_q <= ins_d;
      pc4_q <= pc4_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end
  assign instr_address_o    = pc_q;
  assign ifid_instruction_o = ins_q;
  assign ifid_pc_plus4_o    = pc4_q;
  assign ifid_valid_o       = v_q;
  assign fetch_count_o      = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed and random stimulus, reference model feeding a scoreboard queue.
module tb_instruction_fetch_stage;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, bt = 1'b0, jmp = 1'b0;
  logic [31:0] btgt = '0, jtgt = '0, instr, addr, ifid_ins, ifid_pc4, cnt;
  logic        ifid_v;
  logic [31:0] mem [1024];
  typedef struct packed {
    logic [31:0] pc, ins, pc4, cnt;
    logic        v;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign instr = mem[addr[11:2]];

  instruction_fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_taken_i(bt), .branch_target_i(btgt),
    .jump_i(jmp), .jump_target_i(jtgt),
    .instruction_i(instr), .instr_address_o(addr),
    .ifid_instruction_o(ifid_ins), .ifid_pc_plus4_o(ifid_pc4),
    .ifid_valid_o(ifid_v), .fetch_count_o(cnt)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_all(string tag, exp_t e);
    chk({tag, ".pc"}, addr, e.pc);
    chk({tag, ".ifid_ins"}, ifid_ins, e.ins);
    chk({tag, ".ifid_pc4"}, ifid_pc4, e.pc4);
    chk({tag, ".ifid_valid"}, {31'b0, ifid_v}, {31'b0, e.v});
    chk({tag, ".fetch_count"}, cnt, e.cnt);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk_all("edge", e);
    end
  end

  // Spec-level view: redirect wins over stall, branch over jump; otherwise fetch the word at PC.
  task automatic step(logic b, logic [31:0] bta, logic j, logic [31:0] jta, logic s);
    @(negedge clk);
    #1;
    rst = 1'b0; bt = b; btgt = bta; jmp = j; jtgt = jta; stall = s;
    if (b || j) begin
      m.pc  = b ? (bta & ~32'd3) : (jta & ~32'd3);
      m.ins = 0; m.pc4 = 0; m.v = 0;
    end else if (!s) begin
      m.ins = mem[m.pc[11:2]];
      m.pc4 = m.pc + 4;
      m.v   = 1;
      m.cnt = m.cnt + 1;
      m.pc  = m.pc + 4;
    end
    q.push_back(m);
  endtask

  task automatic free(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i * 3;
    m = '0;
    #2;
    chk_all("reset", '0);
    free(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    free(2);
    step(1, 32'h40, 0, 0, 0);
    free(2);
    step(1, 32'h80, 1, 32'h20, 1);
    free(1);
    step(0, 0, 1, 32'h23, 0);
    free(1);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    free(2);
    @(posedge clk);
    #3;
    chk("directed_q_drained", q.size(), 0);
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 3) == 0);
    step(0, 0, 0, 0, 1);
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk_all("async_reset", '0);
    m = '0;
    q.delete();
    free(3);
    step(0, 0, 0, 0, 1);
    free(2);
    @(posedge clk);
    #3;
    chk("final_q_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch stage of the pipelined MIPS datapath. Owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. Handles stall (hazard unit), redirect from branch/jump resolution, and flush. Directly upstream of the instruction memory and directly feeding the decode stage.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- Clk  input  1  rising-edge clock for all state.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Stall  input  1  hazard-unit hold: PC and IF/ID keep their values.
- BranchTaken  input  1  branch resolved taken (EX stage).
- BranchTarget  input  32  branch destination byte address.
- Jump  input  1  jump/jr decoded (ID stage).
- JumpTarget  input  32  jump destination byte address.
- Instruction  input  32  word returned by instruction memory for InstrAddress (same cycle, combinational).
- InstrAddress  output  32  current PC, drives instruction memory address (bits [11:2] index 1024 words).
- IFID_Instruction  output  32  registered instruction for decode.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
- FetchCount  output  32  number of instructions latched valid into IF/ID.

## Operation
- PC register drives InstrAddress directly; no combinational path from any input to InstrAddress.
- Next-PC selection, highest priority first:
  1. BranchTaken: PC <= {BranchTarget[31:2], 2'b00}; IF/ID flushed.
  2. Jump: PC <= {JumpTarget[31:2], 2'b00}; IF/ID flushed.
  3. Stall: PC, IF/ID, FetchCount all hold.
  4. Otherwise: PC <= PC + 4 (mod 2^32); IF/ID <= {Instruction, PC+4, Valid=1}; FetchCount <= FetchCount + 1.
- BranchTaken and Jump together: branch wins (branch is the older instruction); JumpTarget ignored.
- Redirect overrides Stall: the stalled slot is younger than the resolving branch and is discarded.
- Flush: IFID_Instruction <= 32'h0000_0000 (sll $0,$0,0 = NOP), IFID_PCPlus4 <= 0, IFID_Valid <= 0; FetchCount unchanged.
- Target bits [1:0] silently forced to 0; no exception.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- FetchCount wraps modulo 2^32.

## Timing
- Reset (asynchronous, any time incl. mid-stall or mid-redirect): PC = RESET_PC, IFID_Instruction = 0, IFID_PCPlus4 = 0, IFID_Valid = 0, FetchCount = 0, within the same cycle, independent of Clk.
- First edge after Reset deasserts: IF/ID captures instruction at RESET_PC, IFID_PCPlus4 = RESET_PC+4, IFID_Valid = 1.
- Fetch latency: instruction at PC appears on IFID_* one edge after PC presents it.
- Redirect latency: target is on InstrAddress one edge after the redirect input is sampled; target instruction reaches IFID_* on the following edge; exactly one bubble per redirect.
- Stall held N cycles: outputs frozen for N edges; resume on first edge with Stall=0, no instruction lost or duplicated.
- All inputs sampled on rising Clk only; Instruction must be stable before the edge.

## Test plan
- Reset, RESET_PC=0, memory[i]=i*3, 4 free-running edges -> InstrAddress 0,4,8,12,16; IFID_Instruction 0,3,6,9; IFID_Valid=1 from edge 1; FetchCount=4.
- Stall high for edges 3-5 after reset -> InstrAddress stays 8, IFID_Instruction stays 3, FetchCount stays 2; after release sequence continues 6,9 with no gap or duplicate.
- BranchTaken with BranchTarget=32'h40 while PC=32'h10 -> next edge InstrAddress=32'h40, IFID_Valid=0, IFID_Instruction=0; following edge IFID_Instruction=48, IFID_PCPlus4=32'h44.
- BranchTaken (target 32'h80) and Jump (target 32'h20) and Stall all high same edge -> PC=32'h80, IF/ID flushed, FetchCount unchanged.
- JumpTarget=32'h23 -> PC=32'h20; PC forced to 32'hFFFF_FFFC then one free edge -> PC=32'h0000_0000, IFID_PCPlus4=0.
- Assert Reset asynchronously between edges during an active stall -> all outputs at reset values before the next Clk edge; normal fetch from RESET_PC after release.
